usb_dev_txn_ctrl: RTL

// - Device-side transaction sequencer above usb_link.
// - Decodes received tokens (OUT/IN/SETUP) and drives the DATA and handshake phases.
// - Tracks a DATA0/DATA1 toggle per endpoint and routes payload between usb_link and NUM_EP endpoint buffers.
// - Owns the usb_link TX token/handshake port and the TX data stream; observes the RX pid/data outputs.

---
 rtl/usb_pkg.sv | 28 ++
 rtl/usb_toggle_bank.sv | 29 ++
 rtl/usb_dev_txn_ctrl.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/usb_pkg.sv
// Shared definitions for the USB device transaction sequencer: PID codes,
// sequencer states and a token classifier.
package usb_pkg;

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_SETUP = 4'b1101;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;

  typedef enum logic [2:0] {
    S_IDLE,
    S_IN_PID,
    S_IN_DATA,
    S_IN_WAIT,
    S_OUT_WAIT,
    S_OUT_RX,
    S_HS
  } state_t;

  function automatic logic is_token(input logic [3:0] pid);
    return (pid == PID_OUT) || (pid == PID_IN) || (pid == PID_SETUP);
  endfunction

endpackage

// File: rtl/usb_toggle_bank.sv
// Per-endpoint DATA0/DATA1 toggle bits with one shared index for clear,
// flip and read. Clear wins over flip.
module usb_toggle_bank #(
  parameter int NUM_EP = 4,
  parameter int EPW    = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [EPW-1:0] idx,
  input  logic           flip,
  input  logic           clr,
  output logic           rd
);

  logic [NUM_EP-1:0] bits;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bits <= '0;
    end else if (clr) begin
      bits[idx] <= 1'b0;
    end else if (flip) begin
      bits[idx] <= ~bits[idx];
    end
  end

  assign rd = bits[idx];

endmodule

// File: rtl/usb_dev_txn_ctrl.sv
// Device-side transaction sequencer: decodes tokens, runs IN/OUT data phases
// with per-endpoint data toggles and issues the handshake through usb_link.
module usb_dev_txn_ctrl
  import usb_pkg::*;
#(
  parameter int NUM_EP = 4,
  parameter int EPW    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_pid_en,
  input  logic [3:0]        rx_pid,
  input  logic [3:0]        rx_endp,
  input  logic              crc5_err,
  input  logic              time_out,
  input  logic              rx_lt_sop,
  input  logic              rx_lt_eop,
  input  logic              rx_lt_valid,
  input  logic [7:0]        rx_lt_data,
  output logic              rx_lt_ready,
  output logic [3:0]        tx_pid,
  output logic [6:0]        tx_addr,
  output logic [3:0]        tx_endp,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              tx_lt_sop,
  output logic              tx_lt_eop,
  output logic              tx_lt_valid,
  output logic [7:0]        tx_lt_data,
  output logic              tx_lt_cancle,
  input  logic              tx_lt_ready,
  output logic [EPW-1:0]    ep_sel,
  input  logic [NUM_EP-1:0] in_avail,
  input  logic              in_valid,
  input  logic              in_eop,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              in_done,
  input  logic [NUM_EP-1:0] out_space,
  output logic              out_valid,
  output logic              out_eop,
  output logic [7:0]        out_data,
  input  logic              out_ready,
  output logic              out_commit,
  output logic              out_drop
);

  localparam logic [4:0] NUM_EP_L = 5'(NUM_EP);

  state_t         state, state_nx;
  logic [EPW-1:0] ep_sel_nx;
  logic [3:0]     hs_pid, hs_pid_nx;
  logic           is_setup, is_setup_nx;
  logic           space_q, space_nx;
  logic           dtog_q, dtog_nx;
  logic           pend_q, pend_nx;
  logic [3:0]     pend_pid, pend_pid_nx;
  logic [3:0]     pend_endp, pend_endp_nx;

  logic           tog_rd, tog_flip, tog_clr;
  logic [EPW-1:0] tog_idx;

  logic           tok_live, act;
  logic [3:0]     act_pid, act_endp;
  logic           ep_ok, zlp;
  logic [3:0]     data_pid;
  logic           unused_ok;

  assign unused_ok = rx_lt_sop;
  assign tx_addr   = '0;
  assign tx_endp   = '0;

  // A token that arrives while busy is parked here and served from idle.
  assign tok_live = rx_pid_en && !crc5_err && is_token(rx_pid);
  assign act      = tok_live || pend_q;
  assign act_pid  = tok_live ? rx_pid  : pend_pid;
  assign act_endp = tok_live ? rx_endp : pend_endp;
  assign ep_ok    = {1'b0, act_endp} < NUM_EP_L;
  assign zlp      = in_eop && !in_valid;
  assign data_pid = tog_rd ? PID_DATA1 : PID_DATA0;

  usb_toggle_bank #(.NUM_EP(NUM_EP), .EPW(EPW)) u_toggle (
    .clk   (clk),
    .rst_n (rst_n),
    .idx   (tog_idx),
    .flip  (tog_flip),
    .clr   (tog_clr),
    .rd    (tog_rd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      ep_sel    <= '0;
      hs_pid    <= '0;
      is_setup  <= 1'b0;
      space_q   <= 1'b0;
      dtog_q    <= 1'b0;
      pend_q    <= 1'b0;
      pend_pid  <= '0;
      pend_endp <= '0;
    end else begin
      state     <= state_nx;
      ep_sel    <= ep_sel_nx;
      hs_pid    <= hs_pid_nx;
      is_setup  <= is_setup_nx;
      space_q   <= space_nx;
      dtog_q    <= dtog_nx;
      pend_q    <= pend_nx;
      pend_pid  <= pend_pid_nx;
      pend_endp <= pend_endp_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    ep_sel_nx    = ep_sel;
    hs_pid_nx    = hs_pid;
    is_setup_nx  = is_setup;
    space_nx     = space_q;
    dtog_nx      = dtog_q;
    pend_nx      = pend_q;
    pend_pid_nx  = pend_pid;
    pend_endp_nx = pend_endp;
    tog_idx      = ep_sel;
    tog_flip     = 1'b0;
    tog_clr      = 1'b0;
    rx_lt_ready  = 1'b0;
    tx_pid       = '0;
    tx_valid     = 1'b0;
    tx_lt_sop    = 1'b0;
    tx_lt_eop    = 1'b0;
    tx_lt_valid  = 1'b0;
    tx_lt_data   = '0;
    tx_lt_cancle = 1'b0;
    in_ready     = 1'b0;
    in_done      = 1'b0;
    out_valid    = 1'b0;
    out_eop      = 1'b0;
    out_data     = '0;
    out_commit   = 1'b0;
    out_drop     = 1'b0;

    if (state != S_IDLE && tok_live) begin
      pend_nx      = 1'b1;
      pend_pid_nx  = rx_pid;
      pend_endp_nx = rx_endp;
      state_nx     = S_IDLE;
      tx_lt_cancle = (state == S_IN_DATA);
      out_drop     = (state == S_OUT_RX);
    end else begin
      case (state)
        S_IDLE: begin
          pend_nx = 1'b0;
          if (act) begin
            ep_sel_nx   = act_endp[EPW-1:0];
            is_setup_nx = (act_pid == PID_SETUP);
            if (!ep_ok) begin
              hs_pid_nx = PID_STALL;
              state_nx  = S_HS;
            end else if (act_pid == PID_IN) begin
              if (in_avail[act_endp[EPW-1:0]]) begin
                state_nx = S_IN_PID;
              end else begin
                hs_pid_nx = PID_NAK;
                state_nx  = S_HS;
              end
            end else begin
              tog_idx  = act_endp[EPW-1:0];
              tog_clr  = (act_pid == PID_SETUP);
              state_nx = S_OUT_WAIT;
            end
          end
        end

        S_IN_PID: begin
          tx_lt_valid = 1'b1;
          tx_lt_sop   = 1'b1;
          tx_lt_eop   = zlp;
          tx_lt_data  = {~data_pid, data_pid};
          if (tx_lt_ready) state_nx = zlp ? S_IN_WAIT : S_IN_DATA;
        end

        S_IN_DATA: begin
          tx_lt_valid = in_valid;
          tx_lt_eop   = in_eop;
          tx_lt_data  = in_data;
          in_ready    = tx_lt_ready;
          if (in_valid && tx_lt_ready && in_eop) state_nx = S_IN_WAIT;
        end

        S_IN_WAIT: begin
          if (rx_pid_en) begin
            if (rx_pid == PID_ACK) begin
              tog_flip = 1'b1;
              in_done  = 1'b1;
            end
            state_nx = S_IDLE;
          end else if (time_out) begin
            state_nx = S_IDLE;
          end
        end

        S_OUT_WAIT: begin
          if (rx_pid_en) begin
            if (rx_pid == PID_DATA0 || rx_pid == PID_DATA1) begin
              dtog_nx  = (rx_pid == PID_DATA1);
              space_nx = out_space[ep_sel];
              state_nx = S_OUT_RX;
            end else begin
              state_nx = S_IDLE;
            end
          end else if (time_out) begin
            state_nx = S_IDLE;
          end
        end

        S_OUT_RX: begin
          rx_lt_ready = out_ready;
          out_valid   = rx_lt_valid && space_q;
          out_eop     = rx_lt_valid && rx_lt_eop && space_q;
          out_data    = space_q ? rx_lt_data : 8'h00;
          if (time_out) begin
            out_drop = 1'b1;
            state_nx = S_IDLE;
          end else if (rx_lt_valid && rx_lt_eop && out_ready) begin
            state_nx = S_HS;
            // SETUP must always be accepted, so a full endpoint only loses the data.
            if (!space_q) begin
              out_drop  = 1'b1;
              hs_pid_nx = is_setup ? PID_ACK : PID_NAK;
            end else if (dtog_q != tog_rd) begin
              out_drop  = 1'b1;
              hs_pid_nx = PID_ACK;
            end else begin
              out_commit = 1'b1;
              tog_flip   = 1'b1;
              hs_pid_nx  = PID_ACK;
            end
          end
        end

        S_HS: begin
          tx_valid = 1'b1;
          tx_pid   = hs_pid;
          if (tx_ready) state_nx = S_IDLE;
        end

        default: state_nx = S_IDLE;
      endcase
    end
  end

endmodule
